// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder/subtractor.
// No logic of its own; the nines' complement helper is purely combinational.
// No flow control here; see bcd_addsub_serial for the handshakes.
package bcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ADD,
    FIX,
    DONE
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  // Nines' complement of one decimal digit.
  function automatic logic [3:0] nines(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One decimal digit adder: x + y + cin with +6 correction when the sum exceeds 9.
// Latency: combinational, zero cycles.
// Backpressure: none; the parent sequences the operands.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] s;

  // Binary sum, then decimal correction into the next digit.
  always_comb begin
    s = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    if (s > {1'b0, BCD_MAX}) begin
      digit = s[3:0] + BCD_CORR;
      cout  = 1'b1;
    end else begin
      digit = s[3:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD add/sub with sign-magnitude result and non-BCD detection.
// Latency (accept edge to out_valid): N+2 add/non-negative sub, 2N+2 negative sub, 2 invalid.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [4*N_DIGITS-1:0] a,
  input  logic [4*N_DIGITS-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*N_DIGITS-1:0] result,
  output logic                  carry_out,
  output logic                  negative,
  output logic                  invalid
);

  localparam int W  = 4 * N_DIGITS;
  localparam int CW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_DIGITS - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic [W-1:0]    a_q, b_q;
  logic            sub_q;

  logic [CW+1:0]   base;
  logic            last_dig;
  logic            bad;
  logic [3:0]      a_dig, b_dig, r_dig;
  logic [3:0]      x, y, sum_dig;
  logic            sum_cout;

  assign base     = {cnt, 2'b00};
  assign last_dig = (cnt == LAST);
  assign a_dig    = a_q[base +: 4];
  assign b_dig    = b_q[base +: 4];
  assign r_dig    = result[base +: 4];

  // Flag any captured operand digit outside 0..9.
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (a_q[4*i +: 4] > BCD_MAX || b_q[4*i +: 4] > BCD_MAX) bad = 1'b1;
    end
  end

  // Shared digit adder: A + (B or 9-B) during ADD, (9-R) + carry during FIX.
  always_comb begin
    if (state == FIX) begin
      x = nines(r_dig);
      y = 4'd0;
    end else begin
      x = a_dig;
      y = sub_q ? nines(b_dig) : b_dig;
    end
  end

  bcd_digit_add u_digit (
    .x     (x),
    .y     (y),
    .cin   (carry),
    .digit (sum_dig),
    .cout  (sum_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CHECK;
      end
      CHECK: state_nxt = bad ? DONE : ADD;
      ADD: begin
        // A subtraction without final carry means A<B: recomplement in FIX.
        if (last_dig) state_nxt = (sub_q && !sum_cout) ? FIX : DONE;
      end
      FIX: if (last_dig) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, digit counter, carry chain and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      negative  <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= op_sub;
          end
        end
        CHECK: begin
          cnt       <= '0;
          carry_out <= 1'b0;
          negative  <= 1'b0;
          if (bad) begin
            invalid <= 1'b1;
            result  <= '0;
          end else begin
            invalid <= 1'b0;
            // Subtraction adds the nines' complement plus one.
            carry   <= sub_q;
          end
        end
        ADD: begin
          result[base +: 4] <= sum_dig;
          carry             <= sum_cout;
          cnt               <= last_dig ? '0 : cnt + 1'b1;
          if (last_dig) begin
            if (!sub_q) begin
              carry_out <= sum_cout;
            end else if (!sum_cout) begin
              negative <= 1'b1;
              carry    <= 1'b1;
            end
          end
        end
        FIX: begin
          result[base +: 4] <= sum_dig;
          carry             <= sum_cout;
          cnt               <= last_dig ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Randomised and directed bench for bcd_addsub_serial against an integer reference model.
// Checks result, flags, latency, hold-under-backpressure and asynchronous reset.
// Outputs sampled 1 time unit after the rising edge; inputs driven on the falling edge.
module tb_bcd_addsub_serial;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         negative;
  logic         invalid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_addsub_serial #(.N_DIGITS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .negative  (negative),
    .invalid   (invalid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: decode to integers, do the decimal arithmetic, re-encode.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsub,
                       output logic [W-1:0] r, output logic co, output logic neg,
                       output logic inv, output int lat);
    int av, bv, p, s;
    av = 0; bv = 0; p = 1; inv = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (ta[4*i +: 4] > 4'd9 || tb_v[4*i +: 4] > 4'd9) inv = 1'b1;
      av += int'(ta[4*i +: 4]) * p;
      bv += int'(tb_v[4*i +: 4]) * p;
      p  *= 10;
    end
    co = 1'b0; neg = 1'b0;
    if (inv) begin
      r = '0; lat = 2;
    end else if (!tsub) begin
      s = av + bv;
      co = (s >= p);
      r = to_bcd(s % p);
      lat = N + 2;
    end else if (av >= bv) begin
      r = to_bcd(av - bv);
      lat = N + 2;
    end else begin
      r = to_bcd(bv - av);
      neg = 1'b1;
      lat = 2 * N + 2;
    end
  endtask

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) begin
      v[4*i +: 4] = 4'($urandom_range(0, 9));
      if (allow_bad && $urandom_range(0, 15) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  // Issue one request, wait for the result, check it, hold it for `hold` cycles, then take it.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsub,
                        input int hold);
    logic [W-1:0] er;
    logic eco, eneg, einv;
    int elat, lat, w;
    model(ta, tb_v, tsub, er, eco, eneg, einv, elat);
    @(negedge clk);
    a = ta; b = tb_v; op_sub = tsub; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(elat));
    check("result", 32'(result), 32'(er));
    check("carry_out", 32'(carry_out), 32'(eco));
    check("negative", 32'(negative), 32'(eneg));
    check("invalid", 32'(invalid), 32'(einv));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_result", 32'(result), 32'(er));
      check("hold_flags", {29'd0, carry_out, negative, invalid}, {29'd0, eco, eneg, einv});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_drop", 32'(out_valid), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {29'd0, carry_out, negative, invalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op(16'h1234, 16'h5678, 1'b0, 0);
    run_op(16'h9999, 16'h0001, 1'b0, 0);
    run_op(16'h9999, 16'h9999, 1'b0, 1);
    run_op(16'h5000, 16'h1234, 1'b1, 0);
    run_op(16'h1234, 16'h5000, 1'b1, 0);
    run_op(16'h0042, 16'h0042, 1'b1, 0);
    run_op(16'h0000, 16'h0001, 1'b1, 0);
    run_op(16'h12A4, 16'h0000, 1'b0, 0);
    run_op(16'h0005, 16'h0007, 1'b0, 5);
    run_op(16'h0000, 16'h0000, 1'b1, 0);

    // Asynchronous reset in the middle of ADD.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_flags", {29'd0, carry_out, negative, invalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h1111, 16'h2222, 1'b0, 0);

    // Random traffic, occasionally with non-BCD digits.
    for (int k = 0; k < 40; k++) begin
      run_op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
